// File: rtl/ttt_game_controller_if.sv
// Player-facing signal bundle for ttt_game_controller.
// master = player/host side, slave = the game controller.
interface ttt_game_controller_if;
  logic        start;
  logic [8:0]  PL1_en;
  logic [8:0]  PL2_en;
  logic [17:0] board;
  logic [1:0]  turn;
  logic        illegal_move;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;
  logic        timeout;

  modport master (
    output start, PL1_en, PL2_en,
    input  board, turn, illegal_move, winner, game_over, move_count, timeout
  );

  modport slave (
    input  start, PL1_en, PL2_en,
    output board, turn, illegal_move, winner, game_over, move_count, timeout
  );
endinterface

// File: rtl/ttt_game_controller.sv
// Two-player tic-tac-toe referee: validates moves, keeps the board, detects win/draw.
// Optional per-turn timeout enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_game_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ttt_game_controller_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, P1_TURN, P2_TURN, EVAL, DONE} state_e;

  // Cell masks of the 8 winning lines (bit k = cell k+1)
  localparam logic [7:0][8:0] LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  mc_q, mc_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  mover_q, mover_d;
  logic        illegal_q, illegal_d;

  logic        p2, accept, win;
  logic [8:0]  sel, oth, occ, own;
  logic [1:0]  code;

`ifdef TTT_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    mc_d      = mc_q;
    winner_d  = winner_q;
    mover_d   = mover_q;
    illegal_d = 1'b0;
    accept    = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
    timeout_d = 1'b0;
    timer_d   = '0;
`endif

    p2   = (state_q == P2_TURN);
    sel  = p2 ? bus.PL2_en : bus.PL1_en;
    oth  = p2 ? bus.PL1_en : bus.PL2_en;
    code = p2 ? 2'b10 : 2'b01;

    for (int k = 0; k < 9; k++) begin
      occ[k] = |board_q[2*k +: 2];
      own[k] = (board_q[2*k +: 2] == mover_q);
    end
    win = 1'b0;
    for (int l = 0; l < 8; l++)
      win = win | ((own & LINES[l]) == LINES[l]);

    case (state_q)
      P1_TURN, P2_TURN: begin
        if ((sel | oth) != 9'd0) begin
          if (oth != 9'd0 || $countones(sel) != 1 || (sel & occ) != 9'd0) begin
            illegal_d = 1'b1;
          end else begin
            accept = 1'b1;
            for (int k = 0; k < 9; k++)
              if (sel[k]) board_d[2*k +: 2] = code;
            mc_d    = (mc_q == 4'd9) ? mc_q : mc_q + 4'd1;
            mover_d = code;
            state_d = EVAL;
          end
        end
`ifdef TTT_TURN_TIMEOUT_EN
        // Expiry forfeits the turn; an accepted move in the same cycle still counts
        if (!accept && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          illegal_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = p2 ? P1_TURN : P2_TURN;
        end else if (state_d == state_q) begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      EVAL: begin
        if (win) begin
          winner_d = mover_q;
          state_d  = DONE;
        end else if (mc_q == 4'd9) begin
          winner_d = 2'b11;
          state_d  = DONE;
        end else begin
          state_d = (mover_q == 2'b01) ? P2_TURN : P1_TURN;
        end
      end
      default: ;
    endcase

    if (bus.start) begin
      state_d   = P1_TURN;
      board_d   = '0;
      mc_d      = '0;
      winner_d  = '0;
      illegal_d = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
      timeout_d = 1'b0;
      timer_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      board_q   <= '0;
      mc_q      <= '0;
      winner_q  <= '0;
      mover_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      mc_q      <= mc_d;
      winner_q  <= winner_d;
      mover_q   <= mover_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef TTT_TURN_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.board        = board_q;
  assign bus.turn         = (state_q == P1_TURN) ? 2'b01 :
                            (state_q == P2_TURN) ? 2'b10 : 2'b00;
  assign bus.illegal_move = illegal_q;
  assign bus.winner       = winner_q;
  assign bus.game_over    = (state_q == DONE);
  assign bus.move_count   = mc_q;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Scoreboard bench for ttt_game_controller: stimulus queues expected snapshots,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_ttt_game_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ttt_game_controller_if bus();
  ttt_game_controller #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int          due;
    string       name;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        ill;
    logic [1:0]  win;
    logic        go;
    logic [3:0]  mc;
    logic        to;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [17:0] eb;
  logic [3:0]  emc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.due != cyc)
        $display("FAIL %s: check due at cycle %0d not reached in time (now %0d)", e.name, e.due, cyc);
      else if ({bus.board, bus.turn, bus.illegal_move, bus.winner, bus.game_over, bus.move_count, bus.timeout}
               !== {e.board, e.turn, e.ill, e.win, e.go, e.mc, e.to})
        $display("FAIL %s: got board=%h turn=%b ill=%b win=%b go=%b mc=%0d to=%b, want board=%h turn=%b ill=%b win=%b go=%b mc=%0d to=%b",
                 e.name, bus.board, bus.turn, bus.illegal_move, bus.winner, bus.game_over, bus.move_count, bus.timeout,
                 e.board, e.turn, e.ill, e.win, e.go, e.mc, e.to);
      else
        n_pass++;
    end
  end

  task automatic chk(string nm, logic [17:0] b, logic [1:0] t, logic il, logic [1:0] w,
                     logic g, logic [3:0] m, logic to = 1'b0);
    exp_t x;
    x.due = cyc; x.name = nm; x.board = b; x.turn = t; x.ill = il;
    x.win = w; x.go = g; x.mc = m; x.to = to;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [8:0] a, logic [8:0] b);
    bus.PL1_en = a;
    bus.PL2_en = b;
    tick();
    bus.PL1_en = '0;
    bus.PL2_en = '0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    eb  = '0;
    emc = '0;
    chk("start", 18'h0, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0);
  endtask

  // One accepted move on cell k; checks the EVAL cycle and, unless last, the hand-over
  task automatic play(int k, logic p2, logic last);
    logic [8:0]  s;
    logic [17:0] c;
    s = 9'd1 << (k - 1);
    c = p2 ? 18'd2 : 18'd1;
    drive(p2 ? 9'd0 : s, p2 ? s : 9'd0);
    eb  = eb | (c << (2 * (k - 1)));
    emc = emc + 4'd1;
    chk($sformatf("mv%0d_eval", emc), eb, 2'b00, 1'b0, 2'b00, 1'b0, emc);
    if (!last) begin
      tick();
      chk($sformatf("mv%0d_turn", emc), eb, p2 ? 2'b01 : 2'b10, 1'b0, 2'b00, 1'b0, emc);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.PL1_en = '0;
    bus.PL2_en = '0;
    tick();
    tick();
    chk("reset", 18'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 18'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
    drive(9'h001, 9'h000);
    chk("idle_ignores_sel", 18'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);

    // P1 wins on the top row
    start_game();
    play(1, 1'b0, 1'b0); play(4, 1'b1, 1'b0); play(2, 1'b0, 1'b0);
    play(5, 1'b1, 1'b0); play(3, 1'b0, 1'b1);
    tick();
    chk("p1_win", 18'h00295, 2'b00, 1'b0, 2'b01, 1'b1, 4'd5);
    drive(9'h100, 9'h000);
    chk("done_ignores_sel", 18'h00295, 2'b00, 1'b0, 2'b01, 1'b1, 4'd5);

    // P2 targets the cell P1 just took
    start_game();
    play(5, 1'b0, 1'b0);
    drive(9'h000, 9'h010);
    chk("p2_occupied", 18'h00100, 2'b10, 1'b1, 2'b00, 1'b0, 4'd1);
    tick();
    chk("illegal_one_cycle", 18'h00100, 2'b10, 1'b0, 2'b00, 1'b0, 4'd1);

    // Malformed requests in P1_TURN
    start_game();
    drive(9'h003, 9'h000);
    chk("p1_two_bits", 18'h0, 2'b01, 1'b1, 2'b00, 1'b0, 4'd0);
    tick();
    chk("zero_sel_noop", 18'h0, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0);
    drive(9'h001, 9'h002);
    chk("both_selects", 18'h0, 2'b01, 1'b1, 2'b00, 1'b0, 4'd0);
    drive(9'h000, 9'h001);
    chk("p2_sel_in_p1_turn", 18'h0, 2'b01, 1'b1, 2'b00, 1'b0, 4'd0);

    // Full board without a line
    start_game();
    play(1, 1'b0, 1'b0); play(2, 1'b1, 1'b0); play(3, 1'b0, 1'b0);
    play(5, 1'b1, 1'b0); play(4, 1'b0, 1'b0); play(6, 1'b1, 1'b0);
    play(8, 1'b0, 1'b0); play(7, 1'b1, 1'b0); play(9, 1'b0, 1'b1);
    tick();
    chk("draw", 18'h16A59, 2'b00, 1'b0, 2'b11, 1'b1, 4'd9);

    // Reset mid-game acts without waiting for a clock edge
    start_game();
    play(1, 1'b0, 1'b0); play(5, 1'b1, 1'b0); play(9, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    chk("async_reset", 18'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", 18'h0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
    start_game();

`ifdef TTT_TURN_TIMEOUT_EN
    repeat (15) tick();
    chk("before_timeout", 18'h0, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    tick();
    chk("timeout", 18'h0, 2'b10, 1'b0, 2'b00, 1'b0, 4'd0, 1'b1);
    repeat (15) tick();
    drive(9'h000, 9'h001);
    chk("move_beats_timeout", 18'h00002, 2'b00, 1'b0, 2'b00, 1'b0, 4'd1, 1'b0);
`else
    repeat (20) tick();
    chk("no_timeout", 18'h0, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
`endif

    repeat (3) tick();
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d checks left unmatched, want 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
